// File: rtl/clarke_pkg.sv
// rtl/clarke_pkg.sv - shared Clarke/inverse-Clarke widths and fixed-point constants
// Used by both the forward Clarke (sense path) and inverse Clarke (output path) stages.
package clarke_pkg;

  localparam int D_WIDTH = 18;
  localparam int Q_BITS  = 15;

  typedef logic signed [D_WIDTH-1:0] sample_t;

  // Constants held as value*1e9 so they round exactly in integer arithmetic.
  function automatic int sqrt3_div_2(input int q);
    longint p;
    p = (longint'(866025404) <<< q) + longint'(500000000);
    return int'(p / longint'(1000000000));
  endfunction

  function automatic int one_div_sqrt3(input int q);
    longint p;
    p = (longint'(577350269) <<< q) + longint'(500000000);
    return int'(p / longint'(1000000000));
  endfunction

endpackage

// File: rtl/fx_round_sat.sv
// rtl/fx_round_sat.sv - round-half-up shift of a Q product, offset by -half, then fit to D_WIDTH
// Fit clamps symmetrically when INV_CLARKE_SAT_EN is defined, otherwise wraps.
module fx_round_sat #(
  parameter int D_WIDTH = 18,
  parameter int Q_BITS  = 15,
  parameter bit NEG     = 1'b0
) (
  input  logic signed [D_WIDTH+Q_BITS:0] prod_i,
  input  logic signed [D_WIDTH-1:0]      half_i,
  output logic signed [D_WIDTH-1:0]      y_o,
  output logic                           clamp_o
);

  localparam int PW = D_WIDTH + Q_BITS + 1;
  localparam int WW = D_WIDTH + 2;
  localparam logic signed [PW:0] HALF_LSB =
    {{(PW-Q_BITS+1){1'b0}}, 1'b1, {(Q_BITS-1){1'b0}}};

  logic signed [PW:0]   rnd;
  logic signed [WW-1:0] h;
  logic signed [WW-1:0] r;
  logic signed [WW-1:0] w;

  assign rnd = $signed({prod_i[PW-1], prod_i}) + HALF_LSB;
  assign r   = rnd[PW:Q_BITS];
  assign h   = WW'(half_i);
  assign w   = NEG ? (-h - r) : (r - h);

`ifdef INV_CLARKE_SAT_EN
  localparam logic signed [WW-1:0] MAXV = {3'b000, {(D_WIDTH-1){1'b1}}};
  localparam logic signed [WW-1:0] MINV = -MAXV;

  logic unused_bits;
  assign unused_bits = ^rnd[Q_BITS-1:0];

  always_comb begin
    y_o     = w[D_WIDTH-1:0];
    clamp_o = 1'b0;
    if (w > MAXV) begin
      y_o     = MAXV[D_WIDTH-1:0];
      clamp_o = 1'b1;
    end else if (w < MINV) begin
      y_o     = MINV[D_WIDTH-1:0];
      clamp_o = 1'b1;
    end
  end
`else
  logic unused_bits;
  assign unused_bits = ^{rnd[Q_BITS-1:0], w[WW-1:D_WIDTH]};
  assign y_o         = w[D_WIDTH-1:0];
  assign clamp_o     = 1'b0;
`endif

endmodule

// File: rtl/inv_clarke.sv
// rtl/inv_clarke.sv - 2-stage inverse Clarke (alpha/beta -> a/b/c) with start/done
// Optional macro INV_CLARKE_SAT_EN: clamp outputs and keep a sticky sat_flag.
module inv_clarke
  import clarke_pkg::*;
#(
  parameter int D_WIDTH = clarke_pkg::D_WIDTH,
  parameter int Q_BITS  = clarke_pkg::Q_BITS
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic signed [D_WIDTH-1:0] alpha,
  input  logic signed [D_WIDTH-1:0] beta,
  input  logic                      start,
  input  logic                      clr_sat,
  output logic signed [D_WIDTH-1:0] a,
  output logic signed [D_WIDTH-1:0] b,
  output logic signed [D_WIDTH-1:0] c,
  output logic                      done,
  output logic                      sat_flag
);

  localparam int PW = D_WIDTH + Q_BITS + 1;
  localparam logic signed [Q_BITS:0] K = (Q_BITS+1)'(sqrt3_div_2(Q_BITS));

  logic signed [D_WIDTH-1:0] alpha_s1_q, half_s1_q;
  logic signed [PW-1:0]      prod_s1_q;
  logic                      v1_q;
  logic signed [D_WIDTH-1:0] a_q, b_q, c_q;
  logic                      done_q;
  logic signed [D_WIDTH-1:0] b_d, c_d;
  logic                      clamp_b, clamp_c;

  fx_round_sat #(.D_WIDTH(D_WIDTH), .Q_BITS(Q_BITS), .NEG(1'b0)) u_fit_b (
    .prod_i  (prod_s1_q),
    .half_i  (half_s1_q),
    .y_o     (b_d),
    .clamp_o (clamp_b)
  );

  fx_round_sat #(.D_WIDTH(D_WIDTH), .Q_BITS(Q_BITS), .NEG(1'b1)) u_fit_c (
    .prod_i  (prod_s1_q),
    .half_i  (half_s1_q),
    .y_o     (c_d),
    .clamp_o (clamp_c)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      alpha_s1_q <= '0;
      half_s1_q  <= '0;
      prod_s1_q  <= '0;
      v1_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      done_q     <= 1'b0;
    end else begin
      v1_q <= start;
      if (start) begin
        alpha_s1_q <= alpha;
        half_s1_q  <= alpha >>> 1;
        prod_s1_q  <= PW'(beta) * PW'(K);
      end
      done_q <= v1_q;
      if (v1_q) begin
        a_q <= alpha_s1_q;
        b_q <= b_d;
        c_q <= c_d;
      end
    end
  end

`ifdef INV_CLARKE_SAT_EN
  logic sat_q;

  // A new clamp outranks a same-cycle clear so no saturation event is lost.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sat_q <= 1'b0;
    end else if (v1_q && (clamp_b || clamp_c)) begin
      sat_q <= 1'b1;
    end else if (clr_sat) begin
      sat_q <= 1'b0;
    end
  end

  assign sat_flag = sat_q;
`else
  logic unused_sat;
  assign unused_sat = clamp_b ^ clamp_c ^ clr_sat;
  assign sat_flag   = 1'b0;
`endif

  assign a    = a_q;
  assign b    = b_q;
  assign c    = c_q;
  assign done = done_q;

endmodule

// File: tb/tb_inv_clarke.sv
// tb/tb_inv_clarke.sv - directed-vector bench for inv_clarke (D_WIDTH=18, Q_BITS=15)
// Expected values are hand-computed; build with INV_CLARKE_SAT_EN to exercise clamping.
module tb_inv_clarke;

  logic               clk = 1'b0;
  logic               rstb = 1'b0;
  logic signed [17:0] alpha = '0;
  logic signed [17:0] beta = '0;
  logic               start = 1'b0;
  logic               clr_sat = 1'b0;
  logic signed [17:0] a, b, c;
  logic               done, sat_flag;

  int n_vec = 0;
  int n_bad = 0;

  inv_clarke #(.D_WIDTH(18), .Q_BITS(15)) dut (
    .clk      (clk),
    .rstb     (rstb),
    .alpha    (alpha),
    .beta     (beta),
    .start    (start),
    .clr_sat  (clr_sat),
    .a        (a),
    .b        (b),
    .c        (c),
    .done     (done),
    .sat_flag (sat_flag)
  );

  always #5 clk = ~clk;

`ifdef INV_CLARKE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input int ea, input int eb, input int ec);
    check_val({tag, ".done"}, int'(done), 1);
    check_val({tag, ".a"}, int'(a), ea);
    check_val({tag, ".b"}, int'(b), eb);
    check_val({tag, ".c"}, int'(c), ec);
  endtask

  // Single sample: start for one cycle, done must appear after exactly two edges.
  task automatic one_sample(input string tag, input int al, input int be,
                            input int ea, input int eb, input int ec);
    alpha = 18'(al);
    beta  = 18'(be);
    start = 1'b1;
    step();
    start = 1'b0;
    check_val({tag, ".early"}, int'(done), 0);
    step();
    check_out(tag, ea, eb, ec);
    step();
    check_val({tag, ".pulse"}, int'(done), 0);
  endtask

  int ta[5] = '{2, -3, 0, 0, 100};
  int tb[5] = '{0, 0, 2, -1, 100};
  int xa[5] = '{2, -3, 0, 0, 100};
  int xb[5] = '{-1, 2, 2, -1, 37};
  int xc[5] = '{-1, 2, -2, 1, -137};

  initial begin
    step();
    step();
    check_val("rst.a", int'(a), 0);
    check_val("rst.b", int'(b), 0);
    check_val("rst.c", int'(c), 0);
    check_val("rst.done", int'(done), 0);
    check_val("rst.sat", int'(sat_flag), 0);
    rstb = 1'b1;
    step();

    one_sample("t1", 16384, 0, 16384, -8192, -8192);
    check_val("t1.sat", int'(sat_flag), 0);
    one_sample("t2", 0, 32767, 0, 28377, -28377);
    check_val("t2.sat", int'(sat_flag), 0);

    if (SAT) one_sample("t3", 131071, -131072, 131071, -131071, 47977);
    else     one_sample("t3", 131071, -131072, 131071, 83097, 47977);
    check_val("t3.sat", int'(sat_flag), SAT ? 1 : 0);

    // Five back-to-back starts; after edge k the outputs hold sample k-2.
    for (int k = 1; k <= 7; k++) begin
      if (k <= 5) begin
        alpha = 18'(ta[k-1]);
        beta  = 18'(tb[k-1]);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
      if (k >= 2 && k <= 6) check_out($sformatf("t4.s%0d", k-2), xa[k-2], xb[k-2], xc[k-2]);
      else                  check_val($sformatf("t4.idle%0d", k), int'(done), 0);
    end

    // Reset while a sample sits in stage 1: it must never emerge.
    alpha = 18'(16384);
    beta  = 18'(0);
    start = 1'b1;
    step();
    start = 1'b0;
    rstb  = 1'b0;
    #1;
    check_val("t5.rst.a", int'(a), 0);
    check_val("t5.rst.b", int'(b), 0);
    check_val("t5.rst.sat", int'(sat_flag), 0);
    step();
    rstb = 1'b1;
    check_val("t5.nodone", int'(done), 0);
    step();
    check_val("t5.nodone2", int'(done), 0);
    one_sample("t5.after", -16384, 0, -16384, 8192, 8192);

    // Clear and new clamp in the same cycle: the set must win.
    one_sample("t6.arm", 131071, -131072, 131071, SAT ? -131071 : 83097, 47977);
    check_val("t6.armed", int'(sat_flag), SAT ? 1 : 0);
    alpha = 18'(131071);
    beta  = 18'(-131072);
    start = 1'b1;
    step();
    start   = 1'b0;
    clr_sat = 1'b1;
    step();
    check_val("t6.setwins.done", int'(done), 1);
    check_val("t6.setwins", int'(sat_flag), SAT ? 1 : 0);
    step();
    clr_sat = 1'b0;
    check_val("t6.cleared", int'(sat_flag), 0);
    step();
    check_val("t6.stays", int'(sat_flag), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
